calc1_req_driver: RTL and testbench
===================================

# calc1_req_driver

Request-side driver that sits directly upstream of one `calc1` request port. It queues whole two-operand requests from a producer and serialises each onto the `calc1` two-cycle command protocol: command with operand 1, then a null command with operand 2. It then waits for the port's response pulse and holds the captured result for a consumer. Exactly one request is outstanding at `calc1` at a time, and a response timeout guards against a hung port.

## Interface
- `FIFO_DEPTH`, 2: request queue depth (entries; ≥1).
- `TIMEOUT`, 16: number of WAIT cycles without a response before the request is retired as timed out (≥2).
- `c_clk` input 1: clock. Everything is on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `req_valid` input 1: producer offers a request.
- `req_ready` output 1: the queue can accept a request.
- `req_cmd` input [0:3]: command. Passed to `calc1` unchanged except for 0.
- `req_op1` input [0:31]: operand 1.
- `req_op2` input [0:31]: operand 2.
- `calc_cmd` output [0:3]: drives `calc1` reqN_cmd_in.
- `calc_data` output [0:31]: drives `calc1` reqN_data_in.
- `calc_resp` input [0:1]: from `calc1` out_respN. Nonzero marks a one-cycle response.
- `calc_rdata` input [0:31]: from `calc1` out_dataN.
- `rsp_valid` output 1: the result is held.
- `rsp_ready` input 1: the consumer takes the result.
- `rsp_resp` output [0:1]: response code. 1 = ok, 2 = error, 3 = timeout.
- `rsp_data` output [0:31]: result data.
- `rsp_timeout` output 1: the held result is a timeout.
- `stray_resp` output 1: one-cycle pulse when a `calc1` response is dropped.
- `busy` output 1: the FSM is not in IDLE.

## Operation
- Reset values: `calc_cmd`=0, `calc_data`=0, `rsp_valid`=0, `rsp_resp`=0, `rsp_data`=0, `rsp_timeout`=0, `stray_resp`=0, `busy`=0, queue empty, FSM=IDLE.
- `req_ready` is low while `reset` is high. Otherwise it is high exactly when the queue is not full.
- Queue behaviour:
  - Push on `req_valid && req_ready`.
  - Push and pop in the same cycle are allowed.
  - A push into a full queue cannot occur.
- FSM states: IDLE, SEND1, SEND2, WAIT, HOLD.
- IDLE:
  - If the queue is not empty, pop the head.
  - If the head's `req_cmd` is not 0, go to SEND1.
  - If the head's `req_cmd` is 0, go to HOLD with `rsp_resp`=2 and `rsp_data`=0. Nothing is issued to `calc1`.
- SEND1: `calc_cmd`=cmd, `calc_data`=op1 for exactly one cycle. Then go to SEND2.
- SEND2: `calc_cmd`=0, `calc_data`=op2 for one cycle. Then go to WAIT.
- WAIT:
  - `calc_cmd`=0 and `calc_data`=0.
  - The timeout counter clears on entry and increments every WAIT cycle.
  - If `calc_resp`≠0, capture `calc_resp` and `calc_rdata` into `rsp_resp`/`rsp_data`, set `rsp_timeout`=0, and go to HOLD.
  - Else, if the counter equals TIMEOUT−1, set `rsp_resp`=3, `rsp_data`=0, `rsp_timeout`=1, and go to HOLD.
- HOLD: `rsp_valid`=1. Outputs are stable until `rsp_ready`, which moves the FSM to IDLE.
- Response code 3 is produced only by this block. Any code from `calc1` is forwarded verbatim.
- A nonzero `calc_resp` in any state other than WAIT (for example a late response after a timeout) is discarded and pulses `stray_resp` for one cycle.
- `reset` asserted in any state returns every register to its reset value on that edge. Queued and in-flight requests are lost, and no response is produced.

## Timing
- All outputs are registered except `req_ready`, which is combinational from the queue count and `reset`.
- Request accepted at edge E into an empty queue with the FSM in IDLE:
  - SEND1 values appear after edge E+1.
  - SEND2 values appear after edge E+2.
  - WAIT begins after edge E+3.
- A response sampled at edge W makes `rsp_valid` high after W.
- A timeout gives `rsp_valid` high after exactly TIMEOUT WAIT cycles.
- `rsp_ready` sampled with `rsp_valid` at edge H makes `rsp_valid` low after H. The next pop happens at edge H+1, so there is one IDLE cycle minimum between requests.
- A cmd-0 request sets `rsp_valid` one edge after the pop.
- Producer throughput is at most FIFO_DEPTH requests buffered beyond the one in flight.

## Test plan
- Add: cmd 1, op1 0x00000001, op2 0x01FFFFFF. Bench model replies resp 1, data 0x02000000 three cycles after SEND2. Required: `calc_cmd` is 1 for one cycle with data 0x1, then 0 with data 0x01FFFFFF, and the held response is resp 1, data 0x02000000.
- Overflow passthrough: cmd 1, op1 0xFFFFFFFF, op2 0x1. Model replies resp 2. Required: `rsp_resp`=2, `rsp_timeout`=0.
- Timeout: TIMEOUT=16 and the model never replies. Required: `rsp_valid` rises after exactly 16 WAIT cycles with resp 3 and `rsp_timeout`=1. A model reply injected 5 cycles later pulses `stray_resp` and does not change the held result.
- Backpressure: 4 back-to-back requests with `rsp_ready`=0. Required: 3 are accepted (1 in flight plus 2 queued), `req_ready` drops on the 4th, and after `rsp_ready` pulses, results return in order.
- Cmd 0: request cmd 0 with op1 0x5. Required: `calc_cmd` never leaves 0, and the held result is resp 2, data 0.
- Reset mid-WAIT: assert `reset` for one cycle during WAIT with 2 queued requests. Required: all outputs return to reset values and the queue is empty. A `calc1` reply arriving afterwards pulses `stray_resp` only.

Source files
------------

// File: rtl/calc1_req_driver.sv
// Request-side driver for one calc1 port: queues two-operand requests, issues them
// as a two-cycle command, waits for the response (with timeout) and holds the result.
module calc1_req_driver #(
   parameter int FIFO_DEPTH = 2,
   parameter int TIMEOUT    = 16
) (
   input  logic        c_clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [0:3]  req_cmd,
   input  logic [0:31] req_op1,
   input  logic [0:31] req_op2,
   output logic [0:3]  calc_cmd,
   output logic [0:31] calc_data,
   input  logic [0:1]  calc_resp,
   input  logic [0:31] calc_rdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [0:1]  rsp_resp,
   output logic [0:31] rsp_data,
   output logic        rsp_timeout,
   output logic        stray_resp,
   output logic        busy
);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int TMO_W = $clog2(TIMEOUT);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {ST_IDLE, ST_SEND1, ST_SEND2, ST_WAIT, ST_HOLD} state_t;

   logic [0:3]       r_fifo_cmd [FIFO_DEPTH];
   logic [0:31]      r_fifo_op1 [FIFO_DEPTH];
   logic [0:31]      r_fifo_op2 [FIFO_DEPTH];
   logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push, w_pop, w_empty;
   logic [0:3]       w_head_cmd;
   logic [0:31]      w_head_op1, w_head_op2;

   state_t           r_state, w_state_next;
   logic [TMO_W-1:0] r_tmo_cnt, w_tmo_cnt_next;
   logic [0:31]      r_op2, w_op2_next;
   logic [0:3]       r_calc_cmd, w_calc_cmd_next;
   logic [0:31]      r_calc_data, w_calc_data_next;
   logic             r_rsp_valid, w_rsp_valid_next;
   logic [0:1]       r_rsp_resp, w_rsp_resp_next;
   logic [0:31]      r_rsp_data, w_rsp_data_next;
   logic             r_rsp_timeout, w_rsp_timeout_next;
   logic             r_stray, w_stray_next;
   logic             r_busy;

   assign w_empty    = (r_count == '0);
   assign req_ready  = !reset && (r_count != CNT_FULL);
   assign w_push     = req_valid && req_ready;
   assign w_pop      = (r_state == ST_IDLE) && !w_empty;
   assign w_head_cmd = r_fifo_cmd[r_rd_ptr];
   assign w_head_op1 = r_fifo_op1[r_rd_ptr];
   assign w_head_op2 = r_fifo_op2[r_rd_ptr];

   always_ff @(posedge c_clk) begin
      if (w_push) begin
         r_fifo_cmd[r_wr_ptr] <= req_cmd;
         r_fifo_op1[r_wr_ptr] <= req_op1;
         r_fifo_op2[r_wr_ptr] <= req_op2;
      end
   end

   always_ff @(posedge c_clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_comb begin
      w_state_next       = r_state;
      w_tmo_cnt_next     = r_tmo_cnt;
      w_op2_next         = r_op2;
      w_calc_cmd_next    = r_calc_cmd;
      w_calc_data_next   = r_calc_data;
      w_rsp_valid_next   = r_rsp_valid;
      w_rsp_resp_next    = r_rsp_resp;
      w_rsp_data_next    = r_rsp_data;
      w_rsp_timeout_next = r_rsp_timeout;
      w_stray_next       = (calc_resp != 2'd0) && (r_state != ST_WAIT);
      case (r_state)
         ST_IDLE: begin
            if (!w_empty) begin
               // A zero command is never sent to calc1; it is answered locally as an error.
               if (w_head_cmd != 4'd0) begin
                  w_state_next     = ST_SEND1;
                  w_calc_cmd_next  = w_head_cmd;
                  w_calc_data_next = w_head_op1;
                  w_op2_next       = w_head_op2;
               end else begin
                  w_state_next       = ST_HOLD;
                  w_rsp_valid_next   = 1'b1;
                  w_rsp_resp_next    = 2'd2;
                  w_rsp_data_next    = '0;
                  w_rsp_timeout_next = 1'b0;
               end
            end
         end
         ST_SEND1: begin
            w_state_next     = ST_SEND2;
            w_calc_cmd_next  = '0;
            w_calc_data_next = r_op2;
         end
         ST_SEND2: begin
            w_state_next     = ST_WAIT;
            w_calc_data_next = '0;
            w_tmo_cnt_next   = '0;
         end
         ST_WAIT: begin
            w_tmo_cnt_next = r_tmo_cnt + 1'b1;
            if (calc_resp != 2'd0) begin
               w_state_next       = ST_HOLD;
               w_rsp_valid_next   = 1'b1;
               w_rsp_resp_next    = calc_resp;
               w_rsp_data_next    = calc_rdata;
               w_rsp_timeout_next = 1'b0;
            end else if (r_tmo_cnt == TMO_LAST) begin
               w_state_next       = ST_HOLD;
               w_rsp_valid_next   = 1'b1;
               w_rsp_resp_next    = 2'd3;
               w_rsp_data_next    = '0;
               w_rsp_timeout_next = 1'b1;
            end
         end
         ST_HOLD: begin
            if (rsp_ready) begin
               w_state_next     = ST_IDLE;
               w_rsp_valid_next = 1'b0;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge c_clk) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_tmo_cnt     <= '0;
         r_op2         <= '0;
         r_calc_cmd    <= '0;
         r_calc_data   <= '0;
         r_rsp_valid   <= 1'b0;
         r_rsp_resp    <= '0;
         r_rsp_data    <= '0;
         r_rsp_timeout <= 1'b0;
         r_stray       <= 1'b0;
         r_busy        <= 1'b0;
      end else begin
         r_state       <= w_state_next;
         r_tmo_cnt     <= w_tmo_cnt_next;
         r_op2         <= w_op2_next;
         r_calc_cmd    <= w_calc_cmd_next;
         r_calc_data   <= w_calc_data_next;
         r_rsp_valid   <= w_rsp_valid_next;
         r_rsp_resp    <= w_rsp_resp_next;
         r_rsp_data    <= w_rsp_data_next;
         r_rsp_timeout <= w_rsp_timeout_next;
         r_stray       <= w_stray_next;
         r_busy        <= (w_state_next != ST_IDLE);
      end
   end

   assign calc_cmd    = r_calc_cmd;
   assign calc_data   = r_calc_data;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_resp    = r_rsp_resp;
   assign rsp_data    = r_rsp_data;
   assign rsp_timeout = r_rsp_timeout;
   assign stray_resp  = r_stray;
   assign busy        = r_busy;
endmodule

// File: tb/tb_calc1_req_driver.sv
// Bench for calc1_req_driver: a calc1 responder model plus a result predictor that
// derives each held response from the request, the reply delay and the timeout rule.
module tb_calc1_req_driver;
   localparam int TB_DEPTH = 2;
   localparam int TB_TMO   = 16;

   logic        c_clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [0:3]  req_cmd = '0;
   logic [0:31] req_op1 = '0;
   logic [0:31] req_op2 = '0;
   logic [0:3]  calc_cmd;
   logic [0:31] calc_data;
   logic [0:1]  calc_resp;
   logic [0:31] calc_rdata;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [0:1]  rsp_resp;
   logic [0:31] rsp_data;
   logic        rsp_timeout;
   logic        stray_resp;
   logic        busy;

   logic [0:1]  m_resp = '0, inj_resp = '0;
   logic [0:31] m_rdata = '0, inj_rdata = '0;
   assign calc_resp  = m_resp | inj_resp;
   assign calc_rdata = m_rdata | inj_rdata;

   calc1_req_driver #(.FIFO_DEPTH(TB_DEPTH), .TIMEOUT(TB_TMO)) dut (
      .c_clk(c_clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_cmd(req_cmd), .req_op1(req_op1), .req_op2(req_op2),
      .calc_cmd(calc_cmd), .calc_data(calc_data), .calc_resp(calc_resp),
      .calc_rdata(calc_rdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_resp(rsp_resp), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
      .stray_resp(stray_resp), .busy(busy)
   );

   always #5 c_clk = ~c_clk;

   typedef struct {
      logic [0:3] cmd; logic [0:31] op1; logic [0:31] op2;
      logic [0:1] resp; logic [0:31] data; logic tmo; int waits;
   } exp_t;
   typedef struct {
      logic [0:3] cmd; logic [0:3] cmd2; logic [0:3] wait_cmd;
      logic [0:31] op1; logic [0:31] op2; logic [0:31] wait_data; int waits;
   } iss_t;

   exp_t exp_q[$];
   iss_t issued[$];
   int   n_vec = 0, n_err = 0, n_stray = 0;
   int   m_delay = 2;
   bit   m_reply_en = 1'b1;

   // Reference calc1 arithmetic: resp 1 with result, or resp 2 on overflow/underflow/bad command.
   function automatic logic [33:0] calc_model(input logic [0:3] c, input logic [0:31] a, input logic [0:31] b);
      logic [31:0] x, y;
      logic [32:0] s;
      x = a; y = b;
      case (c)
         4'd1: begin s = {1'b0, x} + {1'b0, y}; return s[32] ? {2'd2, 32'd0} : {2'd1, s[31:0]}; end
         4'd2: return (x < y) ? {2'd2, 32'd0} : {2'd1, x - y};
         4'd5: return {2'd1, x << y[4:0]};
         4'd6: return {2'd1, x >> y[4:0]};
         default: return {2'd2, 32'd0};
      endcase
   endfunction

   function automatic exp_t predict(input logic [0:3] c, input logic [0:31] a, input logic [0:31] b);
      exp_t e;
      logic [33:0] r;
      e.cmd = c; e.op1 = a; e.op2 = b;
      if (c == 4'd0) begin
         e.resp = 2'd2; e.data = '0; e.tmo = 1'b0; e.waits = 0;
      end else if (!m_reply_en || m_delay >= TB_TMO) begin
         e.resp = 2'd3; e.data = '0; e.tmo = 1'b1; e.waits = TB_TMO;
      end else begin
         r = calc_model(c, a, b);
         e.resp = r[33:32]; e.data = r[31:0]; e.tmo = 1'b0; e.waits = m_delay + 1;
      end
      return e;
   endfunction

   // calc1 port model: records each two-cycle command, counts WAIT cycles, replies after m_delay.
   int   m_phase = 0, m_cnt = 0;
   iss_t cur;
   always begin
      @(posedge c_clk); #2;
      m_resp = '0; m_rdata = '0;
      if (stray_resp) n_stray++;
      if (reset) m_phase = 0;
      else case (m_phase)
         0: if (calc_cmd != 4'd0) begin cur.cmd = calc_cmd; cur.op1 = calc_data; m_phase = 1; end
         1: begin cur.cmd2 = calc_cmd; cur.op2 = calc_data; m_phase = 2; m_cnt = 0; end
         default: begin
            if (rsp_valid) begin
               cur.waits = m_cnt; issued.push_back(cur); m_phase = 0;
            end else begin
               if (m_cnt == 0) begin cur.wait_cmd = calc_cmd; cur.wait_data = calc_data; end
               if (m_reply_en && m_cnt == m_delay) {m_resp, m_rdata} = calc_model(cur.cmd, cur.op1, cur.op2);
               m_cnt++;
               if (m_cnt > 1000) m_phase = 0;
            end
         end
      endcase
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge c_clk); #1;
   endtask

   task automatic push_req(input logic [0:3] c, input logic [0:31] a, input logic [0:31] b);
      int t = 0;
      req_valid = 1'b1; req_cmd = c; req_op1 = a; req_op2 = b;
      while (!req_ready && t < 200) begin tick(); t++; end
      check("push_ready", 64'(req_ready), 64'(1));
      exp_q.push_back(predict(c, a, b));
      tick();
      req_valid = 1'b0;
   endtask

   task automatic collect(input int hold);
      int t = 0;
      exp_t e;
      iss_t s;
      while (!rsp_valid && t < 200) begin tick(); t++; end
      check("rsp_valid_rise", 64'(rsp_valid), 64'(1));
      #2;
      if (exp_q.size() == 0) begin
         check("exp_queue_nonempty", 64'(exp_q.size()), 64'(1));
      end else begin
         e = exp_q.pop_front();
         check("rsp_resp", 64'(rsp_resp), 64'(e.resp));
         check("rsp_data", 64'(rsp_data), 64'(e.data));
         check("rsp_timeout", 64'(rsp_timeout), 64'(e.tmo));
         check("busy_hold", 64'(busy), 64'(1));
         if (e.cmd == 4'd0) begin
            check("cmd0_not_issued", 64'(issued.size()), 64'(0));
         end else if (issued.size() == 0) begin
            check("issued_present", 64'(issued.size()), 64'(1));
         end else begin
            s = issued.pop_front();
            $display("txn cmd=%0d op1=%h op2=%h -> resp=%0d data=%h tmo=%0b waits=%0d",
                     s.cmd, s.op1, s.op2, rsp_resp, rsp_data, rsp_timeout, s.waits);
            check("send1_cmd", 64'(s.cmd), 64'(e.cmd));
            check("send1_data", 64'(s.op1), 64'(e.op1));
            check("send2_cmd", 64'(s.cmd2), 64'(0));
            check("send2_data", 64'(s.op2), 64'(e.op2));
            check("wait_cmd", 64'(s.wait_cmd), 64'(0));
            check("wait_data", 64'(s.wait_data), 64'(0));
            check("wait_cycles", 64'(s.waits), 64'(e.waits));
         end
         for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_valid", 64'(rsp_valid), 64'(1));
            check("hold_resp", 64'({rsp_resp, rsp_data}), 64'({e.resp, e.data}));
         end
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("rsp_valid_fall", 64'(rsp_valid), 64'(0));
      check("busy_idle", 64'(busy), 64'(0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int st;
      tick(); tick();
      check("reset_req_ready", 64'(req_ready), 64'(0));
      reset = 1'b0;
      #1;
      check("reset_req_ready_release", 64'(req_ready), 64'(1));
      check("reset_outputs", 64'({calc_cmd, rsp_valid, rsp_resp, rsp_timeout, stray_resp, busy}), 64'(0));
      check("reset_data", 64'({calc_data, rsp_data}), 64'(0));

      // Add and overflow passthrough
      m_reply_en = 1'b1; m_delay = 2;
      push_req(4'd1, 32'h0000_0001, 32'h01FF_FFFF);
      collect(2);
      push_req(4'd1, 32'hFFFF_FFFF, 32'h0000_0001);
      collect(1);

      // Timeout, then a late reply while holding
      m_reply_en = 1'b0;
      st = n_stray;
      push_req(4'd2, 32'h0000_0009, 32'h0000_0004);
      exp_q[0].resp = 2'd3; exp_q[0].data = '0; exp_q[0].tmo = 1'b1; exp_q[0].waits = TB_TMO;
      begin
         int t = 0;
         while (!rsp_valid && t < 200) begin tick(); t++; end
      end
      repeat (5) tick();
      inj_resp = 2'd1; inj_rdata = 32'hDEAD_BEEF;
      tick();
      inj_resp = '0; inj_rdata = '0;
      check("late_stray_pulse", 64'(stray_resp), 64'(1));
      check("late_hold_resp", 64'({rsp_valid, rsp_resp, rsp_timeout, rsp_data}), 64'({1'b1, 2'd3, 1'b1, 32'd0}));
      tick();
      check("late_stray_clear", 64'(stray_resp), 64'(0));
      collect(0);
      check("late_stray_count", 64'(n_stray - st), 64'(1));

      // Backpressure: three accepted, fourth stalls, results in order
      m_reply_en = 1'b1; m_delay = 1;
      push_req(4'd1, 32'd10, 32'd20);
      push_req(4'd2, 32'd50, 32'd8);
      push_req(4'd5, 32'd3, 32'd4);
      req_valid = 1'b1; req_cmd = 4'd6; req_op1 = 32'h8000_0000; req_op2 = 32'd31;
      check("bp_full_ready", 64'(req_ready), 64'(0));
      repeat (3) begin tick(); check("bp_stall_ready", 64'(req_ready), 64'(0)); end
      req_valid = 1'b0;
      collect(0); collect(1); collect(0);
      push_req(4'd6, 32'h8000_0000, 32'd31);
      collect(0);

      // Cmd 0 is answered locally one edge after the pop
      push_req(4'd0, 32'h0000_0005, 32'h0000_0000);
      tick();
      check("cmd0_latency", 64'(rsp_valid), 64'(1));
      check("cmd0_calc_cmd", 64'(calc_cmd), 64'(0));
      collect(1);

      // Randomized requests with random reply delays around the timeout boundary
      for (int i = 0; i < 14; i++) begin
         logic [0:3] c;
         c = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
         m_delay = (i == 0) ? TB_TMO - 1 : (i == 1) ? TB_TMO : $urandom_range(0, TB_TMO + 2);
         push_req(c, $urandom, (c == 4'd5 || c == 4'd6) ? 32'($urandom_range(0, 31)) : $urandom);
         collect($urandom_range(0, 3));
      end

      // Reset during WAIT with two requests queued
      m_reply_en = 1'b0;
      st = n_stray;
      push_req(4'd1, 32'd1, 32'd2);
      push_req(4'd1, 32'd3, 32'd4);
      push_req(4'd1, 32'd5, 32'd6);
      check("rst_queue_full", 64'(req_ready), 64'(0));
      repeat (3) tick();
      check("rst_busy_before", 64'(busy), 64'(1));
      reset = 1'b1;
      tick();
      check("rst_req_ready_low", 64'(req_ready), 64'(0));
      check("rst_outputs", 64'({calc_cmd, rsp_valid, rsp_resp, rsp_timeout, stray_resp, busy}), 64'(0));
      check("rst_data", 64'({calc_data, rsp_data}), 64'(0));
      reset = 1'b0;
      #1;
      check("rst_queue_empty", 64'(req_ready), 64'(1));
      exp_q.delete();
      repeat (4) begin
         tick();
         check("rst_stays_idle", 64'({busy, calc_cmd, rsp_valid}), 64'(0));
      end
      inj_resp = 2'd1; inj_rdata = 32'h1234_5678;
      tick();
      inj_resp = '0; inj_rdata = '0;
      check("rst_stray_pulse", 64'(stray_resp), 64'(1));
      check("rst_no_result", 64'({rsp_valid, busy, rsp_resp, rsp_data}), 64'(0));
      tick(); #2;
      check("rst_stray_count", 64'(n_stray - st), 64'(1));
      check("no_leftover_issue", 64'(issued.size()), 64'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
